imem_loader: RTL
================

# imem_loader

Synthesizable program-memory loader that replaces simulation-only hex preloading. Accepts a framed byte stream (word count, big-endian 16-bit instruction words, XOR checksum) over a valid/ready interface and writes each assembled word into the stage-1 program memory. Holds the core in reset via `core_hold` until the image is complete and verified. Sits beside `top`, between a host byte source (UART receiver or bench driver) and the program memory write port.

## Interface
- `ADDR_W`, default 8: program memory address width; maximum image is 2^ADDR_W words.
- `DATA_W`, default 16: instruction word width; fixed at 16, two bytes per word.

- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low; `rst` = 0 resets the block immediately.
- `start`  input  1  pulse; restarts loading from DONE or ERR, ignored in all other states.
- `rx_valid`  input  1  byte available on `rx_data`.
- `rx_data`  input  8  stream byte.
- `rx_ready`  output  1  loader can accept a byte; a byte transfers when `rx_valid` and `rx_ready` are both 1 on a rising edge.
- `mem_we`  output  1  program memory write strobe, one cycle per word.
- `mem_addr`  output  ADDR_W  word address for the write.
- `mem_wdata`  output  DATA_W  word to write.
- `core_hold`  output  1  holds the core in reset; 1 except in DONE.
- `done`  output  1  image loaded and checksum matched.
- `error`  output  1  count out of range or checksum mismatch.

## Operation
- Frame format: CNT_HI, CNT_LO, then N words sent high byte first, then CHK. CHK is the XOR of all 2N data bytes. Count bytes are excluded from CHK.
- States: CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR.
- CNT_HI: accept byte into `count[15:8]` -> CNT_LO.
- CNT_LO: accept byte into `count[7:0]`.
  - count = 0 -> CHK.
  - count > 2^ADDR_W -> ERR.
  - otherwise -> DATA_HI, with word index = 0 and running XOR = 0.
- DATA_HI: accept byte into `word[15:8]` and XOR it into the running XOR -> DATA_LO.
- DATA_LO: accept byte into `word[7:0]` and XOR it into the running XOR -> WRITE.
- WRITE: `mem_we` = 1 for exactly one cycle, `mem_addr` = index, `mem_wdata` = word.
  - index = count-1 -> CHK.
  - otherwise index+1 -> DATA_HI.
  - Index width is ADDR_W; it never wraps because count ≤ 2^ADDR_W.
- CHK: accept one byte.
  - Byte equals the running XOR -> DONE.
  - Otherwise -> ERR.
- DONE: `core_hold` = 0 and `done` = 1. `start` -> CNT_HI with `core_hold` = 1.
- ERR: `error` = 1 and `core_hold` = 1. `start` -> CNT_HI.
- `rx_ready` = 1 in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHK; 0 in WRITE, DONE and ERR.
- Bytes presented while `rx_ready` = 0 are not consumed. The source must hold them until they are accepted.
- `start` in any state other than DONE or ERR is ignored.
- Memory contents written before an error or reset remain in memory; the loader never clears memory.

## Timing
- Reset values: state CNT_HI, `rx_ready` = 1, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `core_hold` = 1, `done` = 0, `error` = 0. Count, index, word and running XOR are all 0.
- All outputs are registered or decoded from the state register only; there is no combinational path from `rx_valid`/`rx_data` to any output.
- Throughput: at most 1 byte per cycle; each word takes at least 3 cycles (DATA_HI, DATA_LO, WRITE).
- Latency:
  - `mem_we` is high in the cycle immediately after the low byte is accepted.
  - `done`/`error` assert in the cycle after the CHK byte (or the failing CNT_LO byte) is accepted.
  - `core_hold` falls in the same cycle that `done` rises.
- Minimum frame of N words, streamed back-to-back with no gaps: 2 + 3N + 1 cycles from the first acceptance to `done`.
- Gaps (`rx_valid` = 0) stall the current state with no side effects.
- Asynchronous reset mid-frame:
  - All outputs return to reset values immediately; `mem_we` drops without waiting for a clock.
  - Loading restarts at CNT_HI after `rst` deasserts.
- Simultaneous `start` and `rx_valid` in DONE or ERR: the state moves to CNT_HI and the byte is not consumed, because `rx_ready` was 0 in that cycle.

## Test plan
- Nominal load: stream 00 02 12 34 AB CD 40 -> writes 0x1234 at address 0 and 0xABCD at address 1, one `mem_we` pulse each; `done` = 1, `core_hold` = 0, `error` = 0.
- Bad checksum: stream 00 01 00 01 00 -> word 0x0001 written at address 0; `error` = 1, `core_hold` stays 1, `done` = 0.
- Boundaries with ADDR_W = 8:
  - Count 0x0100 with 256 words and the correct CHK -> last write at address 0xFF, then `done`.
  - Count 0x0101 -> ERR after the CNT_LO byte, with no `mem_we` pulses.
  - Count 0x0000 followed by CHK 00 -> `done` with no writes.
- Backpressure and gaps: random `rx_valid` gaps plus bytes held during WRITE -> the same memory image and `done` timing as the nominal case, shifted only by the gap cycles; no byte lost or duplicated.
- Reset mid-frame: drive `rst` = 0 after the DATA_LO byte of word 1 -> `mem_we` = 0 and `core_hold` = 1 immediately; then stream a full frame -> clean `done`.
- Restart: after DONE, pulse `start` together with `rx_valid` -> state CNT_HI, the byte held and then accepted on the next cycle; `start` pulsed mid-frame has no effect.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the stage-1 program memory
// Holds the core in reset until the image is written and its XOR checksum matches.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_CNT = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          xor_q, xor_d;
  logic                accept;
  logic [15:0]         cnt_new;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CNT_HI;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      xor_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    word_d  = word_q;
    xor_d   = xor_q;
    accept  = rx_valid && rx_ready;
    cnt_new = {count_q[15:8], rx_data};
    case (state_q)
      S_CNT_HI: if (accept) begin
        count_d[15:8] = rx_data;
        state_d       = S_CNT_LO;
      end
      S_CNT_LO: if (accept) begin
        count_d = cnt_new;
        idx_d   = '0;
        xor_d   = '0;
        if (cnt_new == 16'd0)                state_d = S_CHK;
        else if ({1'b0, cnt_new} > MAX_CNT)  state_d = S_ERR;
        else                                 state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept) begin
        word_d[DATA_W-1:8] = rx_data;
        xor_d              = xor_q ^ rx_data;
        state_d            = S_DATA_LO;
      end
      S_DATA_LO: if (accept) begin
        word_d[7:0] = rx_data;
        xor_d       = xor_q ^ rx_data;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        // count never exceeds 2^ADDR_W here, so the index cannot wrap
        if (17'(idx_q) == 17'(count_q) - 17'd1) begin
          state_d = S_CHK;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DATA_HI;
        end
      end
      S_CHK: if (accept) begin
        state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
      end
      S_DONE:  if (start) state_d = S_CNT_HI;
      S_ERR:   if (start) state_d = S_CNT_HI;
      default: state_d = S_CNT_HI;
    endcase
  end

  always_comb begin
    rx_ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                (state_q == S_CHK);
    mem_we    = (state_q == S_WRITE);
    mem_addr  = idx_q;
    mem_wdata = word_q;
    core_hold = (state_q != S_DONE);
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERR);
  end

endmodule
